// File: rtl/gf2m_ds_mult.sv
// Digit-serial GF(2^M) multiplier, c = a*b mod f(x), MSB digit of b first, valid/ready on both sides.
// Optional GF2M_DS_SQR_EN adds sq_mode: single-step a^2 mod f via bit-spread plus reduction.
module gf2m_ds_mult #(
  parameter int             M    = 163,
  parameter int             D    = 8,
  parameter logic [M-1:0]   POLY = {{(M-8){1'b0}}, 8'hC9}
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
`ifdef GF2M_DS_SQR_EN
  input  logic         sq_mode,
`endif
  output logic         in_ready,
  input  logic [M-1:0] a,
  input  logic [M-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [M-1:0] c
);

  localparam int N  = (M + D - 1) / D;
  localparam int W  = N * D;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, state_nxt;
  logic [M-1:0]  a_r, acc, acc_nxt, c_r;
  logic [W-1:0]  b_r;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [M+D-1:0] prod;
  logic [D-1:0]  digit;

  // Overflow bits are folded highest first, so a fold that lands above M is caught by a later k.
  function automatic logic [M-1:0] fold_d(input logic [M+D-1:0] t);
    logic [M+D-1:0] f, v;
    f = '0;
    f[M-1:0] = POLY;
    f[M] = 1'b1;
    v = t;
    for (int k = D - 1; k >= 0; k--)
      if (v[M+k]) v = v ^ (f << k);
    return v[M-1:0];
  endfunction

`ifdef GF2M_DS_SQR_EN
  logic sq_r;

  function automatic logic [M-1:0] sqr(input logic [M-1:0] x);
    logic [2*M-1:0] f, v;
    v = '0;
    for (int i = 0; i < M; i++) v[2*i] = x[i];
    f = '0;
    f[M-1:0] = POLY;
    f[M] = 1'b1;
    for (int k = M - 1; k >= 0; k--)
      if (v[M+k]) v = v ^ (f << k);
    return v[M-1:0];
  endfunction
`endif

  assign digit = b_r[W-1 -: D];

  always_comb begin
    prod = {acc, {D{1'b0}}};
    for (int j = 0; j < D; j++)
      if (digit[j]) prod = prod ^ ({{D{1'b0}}, a_r} << j);
    acc_nxt = fold_d(prod);
    cnt_nxt = cnt + 1'b1;
`ifdef GF2M_DS_SQR_EN
    if (sq_r) begin
      acc_nxt = sqr(a_r);
      cnt_nxt = CW'(N);
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)        state_nxt = RUN;
      RUN:     if (cnt == CW'(N))   state_nxt = DONE;
      DONE:    if (out_ready)       state_nxt = IDLE;
      default:                      state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  assign c = c_r;

  // RUN spends N cycles on digits, then one more cycle publishing acc into c.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r <= '0;
      b_r <= '0;
      acc <= '0;
      c_r <= '0;
      cnt <= '0;
`ifdef GF2M_DS_SQR_EN
      sq_r <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_r <= a;
          b_r <= W'(b);
          acc <= '0;
          cnt <= '0;
`ifdef GF2M_DS_SQR_EN
          sq_r <= sq_mode;
`endif
        end
        RUN: if (cnt != CW'(N)) begin
          acc <= acc_nxt;
          b_r <= b_r << D;
          cnt <= cnt_nxt;
        end else begin
          c_r <= acc;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gf2m_ds_mult.sv
// Bench for gf2m_ds_mult: directed vector table, handshake/reset corner sequences,
// and random pairs against a bit-serial shift-and-add reference.
module tb_gf2m_ds_mult;
  localparam int M = 163;
  localparam int D = 8;
  localparam int N = 21;
  localparam logic [M-1:0] POLY = {{(M-8){1'b0}}, 8'hC9};

  logic         clk, rst_n, in_valid, in_ready, out_valid, out_ready;
  logic [M-1:0] a, b, c;
`ifdef GF2M_DS_SQR_EN
  logic         sq_mode;
`endif

  int errors = 0;
  int checks = 0;

  gf2m_ds_mult #(.M(M), .D(D), .POLY(POLY)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
`ifdef GF2M_DS_SQR_EN
    .sq_mode(sq_mode),
`endif
    .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .c(c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic [M-1:0] a;
    logic [M-1:0] b;
    logic [M-1:0] exp;
  } vec_t;

  vec_t tbl[6];

  // Bit-serial reference: r = r*x mod f, then add a for each set bit of y, MSB first.
  function automatic logic [M-1:0] ref_mul(input logic [M-1:0] x, input logic [M-1:0] y);
    logic [M-1:0] r;
    logic top;
    r = '0;
    for (int i = M - 1; i >= 0; i--) begin
      top = r[M-1];
      r = r << 1;
      if (top) r = r ^ POLY;
      if (y[i]) r = r ^ x;
    end
    return r;
  endfunction

  function automatic logic [M-1:0] rand_m();
    logic [191:0] r;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    return r[M-1:0];
  endfunction

  task automatic chk(input string name, input logic [M-1:0] act, input logic [M-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic run_op(input logic [M-1:0] ta, input logic [M-1:0] tb_b, input logic sq,
                        output logic [M-1:0] res, output int lat, output logic busy_ok);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    a = ta;
    b = tb_b;
    in_valid = 1'b1;
`ifdef GF2M_DS_SQR_EN
    sq_mode = sq;
`else
    if (sq) $display("note: square request ignored without GF2M_DS_SQR_EN");
`endif
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = rand_m();
    b = rand_m();
`ifdef GF2M_DS_SQR_EN
    sq_mode = 1'b0;
`endif
    lat = 0;
    busy_ok = 1'b1;
    do begin
      @(posedge clk);
      #1;
      lat++;
      if (in_ready) busy_ok = 1'b0;
    end while (!out_valid && lat < 100);
    res = c;
  endtask

  initial begin
    logic [M-1:0] res, x162, e324, ra, rb, held;
    int lat;
    logic busy_ok, stable, seen;

    x162 = '0; x162[162] = 1'b1;
    e324 = '0; e324[161] = 1'b1; e324[12] = 1'b1; e324[10] = 1'b1; e324[5] = 1'b1; e324[1] = 1'b1;
    ra = rand_m(); ra[0] = 1'b1;
    rb = rand_m(); rb[3] = 1'b1;
    tbl[0] = '{a: M'(1),    b: M'(1),    exp: M'(1)};
    tbl[1] = '{a: M'(2),    b: x162,     exp: POLY};
    tbl[2] = '{a: x162,     b: x162,     exp: e324};
    tbl[3] = '{a: M'(3),    b: M'(3),    exp: M'(5)};
    tbl[4] = '{a: ra,       b: '0,       exp: '0};
    tbl[5] = '{a: '0,       b: rb,       exp: '0};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
`ifdef GF2M_DS_SQR_EN
    sq_mode = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready", M'(in_ready), M'(1));
    chk("reset_out_valid", M'(out_valid), M'(0));
    chk("reset_c", c, '0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      run_op(tbl[i].a, tbl[i].b, 1'b0, res, lat, busy_ok);
      chk($sformatf("vec%0d_c", i), res, tbl[i].exp);
      chk($sformatf("vec%0d_latency", i), M'(lat), M'(N + 1));
      chk($sformatf("vec%0d_busy_in_ready", i), M'(busy_ok), M'(1));
    end

    // result consumed on the next edge, in_ready back in the same post-edge cycle
    @(posedge clk);
    #1;
    chk("consume_out_valid", M'(out_valid), M'(0));
    chk("consume_in_ready", M'(in_ready), M'(1));

    // back-pressure: hold DONE for 10 cycles while in_valid pulses
    out_ready = 1'b0;
    ra = rand_m(); rb = rand_m();
    run_op(ra, rb, 1'b0, res, lat, busy_ok);
    held = ref_mul(ra, rb);
    chk("hold_c", res, held);
    stable = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      in_valid = k[0];
      a = rand_m(); b = rand_m();
      @(posedge clk);
      #1;
      if (!out_valid || in_ready || c !== held) stable = 1'b0;
    end
    chk("hold_stable", M'(stable), M'(1));
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("release_out_valid", M'(out_valid), M'(0));
    chk("release_in_ready", M'(in_ready), M'(1));

    // reset in the middle of RUN
    @(negedge clk);
    a = M'(7); b = M'(9); in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midreset_in_ready", M'(in_ready), M'(1));
    chk("midreset_out_valid", M'(out_valid), M'(0));
    chk("midreset_c", c, '0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    chk("midreset_no_result", M'(seen), M'(0));
    run_op(M'(3), M'(3), 1'b0, res, lat, busy_ok);
    chk("after_reset_c", res, M'(5));
    chk("after_reset_latency", M'(lat), M'(N + 1));

`ifdef GF2M_DS_SQR_EN
    run_op(x162, rand_m(), 1'b1, res, lat, busy_ok);
    chk("sq_c", res, e324);
    chk("sq_latency", M'(lat), M'(2));
    ra = rand_m();
    run_op(ra, rand_m(), 1'b1, res, lat, busy_ok);
    chk("sq_rand_c", res, ref_mul(ra, ra));
`endif

    for (int i = 0; i < 200; i++) begin
      ra = rand_m(); rb = rand_m();
      run_op(ra, rb, 1'b0, res, lat, busy_ok);
      chk($sformatf("rand%0d_c", i), res, ref_mul(ra, rb));
      if (lat != N + 1) chk($sformatf("rand%0d_latency", i), M'(lat), M'(N + 1));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
